// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
// Word handshake between a producer (TX FIFO or host logic) and the UART
// transmitter. A word moves on any clock edge where din_valid and din_ready
// are both high.
//   din        word to send, LSB first; bits above the frame width are ignored
//   din_valid  producer has a word available
//   din_ready  transmitter is idle and can take a word
interface uart_tx_param_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] din;
    logic                     din_valid;
    logic                     din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter. Sends 5..MAX_DATA_BITS data bits LSB first,
// an optional parity bit and 1, 1.5 or 2 stop bits. Bit timing comes from the
// shared oversampling baud_pulse, OVERSAMPLE pulses per bit.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   baud_pulse      1-clk tick, OVERSAMPLE per bit period
//   host            word handshake (din / din_valid / din_ready)
//   data_bits       data bits per frame, clamped into 5..MAX_DATA_BITS
//   pen, eps        parity enable, even parity select
//   sticky_parity   stick parity: bit forced to ~eps
//   stop_cfg        00 = 1 stop, 01 = 1.5 stop, 1x = 2 stop
//   set_break       force tx low without disturbing frame timing
//   tx              registered serial line, idle high
//   busy            frame in progress
//   frame_done      1-clk pulse when the last stop pulse is consumed
module uart_tx_param #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_pulse,
    uart_tx_param_if.slave      host,
    input  logic [3:0]          data_bits,
    input  logic                pen,
    input  logic                eps,
    input  logic                sticky_parity,
    input  logic [1:0]          stop_cfg,
    input  logic                set_break,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] BIT_LOAD    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LOAD = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] STOP2_LOAD  = TW'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]    MAX_BITS    = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [TW-1:0]            timer;
    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [MAX_DATA_BITS-1:0] din_masked;
    logic [3:0]               bit_cnt;
    logic [3:0]               nbits;
    logic [3:0]               bits_clamped;
    logic                     par_en;
    logic                     par_bit;
    logic                     par_calc;
    logic [1:0]               stop_sel;
    logic [TW-1:0]            stop_len;
    logic                     line;
    logic                     accept;
    logic                     bit_end;
    logic                     last_data;

    assign host.din_ready = (state == IDLE) && !rst;
    assign accept         = host.din_valid && host.din_ready;
    assign busy           = (state != IDLE);
    assign bit_end        = baud_pulse && (timer == '0);
    assign last_data      = (bit_cnt == nbits - 4'd1);

    // Frame configuration as it would be latched on an accept edge: width
    // clamped, unused din bits cleared so the shifter and parity only see
    // the bits that will actually be sent.
    always_comb begin
        bits_clamped = data_bits;
        if (data_bits < 4'd5)
            bits_clamped = 4'd5;
        else if (data_bits > MAX_BITS)
            bits_clamped = MAX_BITS;

        din_masked = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            din_masked[i] = host.din[i] && (i < int'(bits_clamped));

        case ({sticky_parity, eps})
            2'b00:   par_calc = ~(^din_masked);
            2'b01:   par_calc = ^din_masked;
            2'b10:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    // Stop length in baud pulses minus one, from the latched stop selection.
    always_comb begin
        case (stop_sel)
            2'b00:   stop_len = BIT_LOAD;
            2'b01:   stop_len = STOP15_LOAD;
            default: stop_len = STOP2_LOAD;
        endcase
    end

    // Next-state logic; every non-idle state leaves only at the end of a bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_data) state_next = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Datapath: the bit timer only moves on baud_pulse outside IDLE, so the
    // pulse that may coincide with the accept edge never shortens the start
    // bit. The line value for the next bit is chosen on the edge that ends
    // the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            nbits      <= 4'd5;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            stop_sel   <= 2'b00;
            line       <= 1'b1;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            tx         <= line & ~set_break;
            if (state == IDLE) begin
                if (accept) begin
                    shift_reg <= din_masked;
                    nbits     <= bits_clamped;
                    par_en    <= pen;
                    par_bit   <= par_calc;
                    stop_sel  <= stop_cfg;
                    bit_cnt   <= '0;
                    timer     <= BIT_LOAD;
                    line      <= 1'b0;
                end
            end else if (baud_pulse) begin
                if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else begin
                    case (state)
                        START: begin
                            line  <= shift_reg[0];
                            timer <= BIT_LOAD;
                        end
                        DATA: begin
                            if (last_data) begin
                                line  <= par_en ? par_bit : 1'b1;
                                timer <= par_en ? BIT_LOAD : stop_len;
                            end else begin
                                shift_reg <= shift_reg >> 1;
                                line      <= shift_reg[1];
                                bit_cnt   <= bit_cnt + 4'd1;
                                timer     <= BIT_LOAD;
                            end
                        end
                        PARITY: begin
                            line  <= 1'b1;
                            timer <= stop_len;
                        end
                        STOP:    frame_done <= 1'b1;
                        default: line <= 1'b1;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Directed bench for uart_tx_param (OVERSAMPLE=16, MAX_DATA_BITS=9). A
// monitor logs tx / frame_done / din_ready / busy after every clock edge,
// indexed by edge number, and each scenario task compares the log against
// hand-computed frame timing.
module tb_uart_tx_param;
    localparam int OS   = 16;
    localparam int MDB  = 9;
    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic [3:0] data_bits;
    logic       pen, eps, sticky_parity, set_break;
    logic [1:0] stop_cfg;
    logic       tx, busy, frame_done;
    logic       baud_gate = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic txlog   [LOGN];
    logic fdlog   [LOGN];
    logic rdylog  [LOGN];
    logic busylog [LOGN];

    uart_tx_param_if #(.MAX_DATA_BITS(MDB)) bus ();

    uart_tx_param #(.OVERSAMPLE(OS), .MAX_DATA_BITS(MDB)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .host          (bus),
        .data_bits     (data_bits),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .stop_cfg      (stop_cfg),
        .set_break     (set_break),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial forever #5 clk = ~clk;

    // Edge counter: cyc is the number of the most recent rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Baud source: every clock, or every other clock when gated.
    initial begin
        baud_pulse = 1'b1;
        forever begin
            @(negedge clk);
            baud_pulse = baud_gate ? ~baud_pulse : 1'b1;
        end
    end

    // Output log, sampled mid-cycle: entry n holds values after edge n.
    initial forever begin
        @(negedge clk);
        txlog[cyc % LOGN]   = tx;
        fdlog[cyc % LOGN]   = frame_done;
        rdylog[cyc % LOGN]  = bus.din_ready;
        busylog[cyc % LOGN] = busy;
    end

    // Expected line bits: index 0 start, data LSB first, optional parity,
    // then ones for the stop bits.
    function automatic logic [15:0] make_frame(input logic [8:0] d, input int nd,
                                               input logic has_par, input logic pbit);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1+i] = d[i];
        if (has_par) f[1+nd] = pbit;
        return f;
    endfunction

    // Offers one word on a falling edge; acc returns the accept edge number.
    task automatic start_word(input logic [8:0] d, input logic [3:0] nb, input logic p,
                              input logic e, input logic s, input logic [1:0] sc,
                              output int acc);
        @(negedge clk);
        bus.din       = d;
        data_bits     = nb;
        pen           = p;
        eps           = e;
        sticky_parity = s;
        stop_cfg      = sc;
        bus.din_valid = 1'b1;
        acc           = cyc + 1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    // Waits a bounded number of cycles for frame_done; dcyc = -1 on timeout.
    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
        vectors++;
        if (bus.din_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", bus.din_ready); end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.din_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_reset: got %b want 1", bus.din_ready); end
    endtask

    task automatic test_frame_timing();
        int acc, d, k;
        logic [15:0] f;
        logic rdy_bad;
        f = make_frame(9'h055, 8, 1'b0, 1'b0);
        start_word(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        wait_done(400, d);
        vectors++;
        if (d - acc !== 160) begin miscompares++; $display("[TB] FAIL frame55_done: got %0d clk want 160", d - acc); end
        vectors++;
        if (txlog[acc % LOGN] !== 1'b1) begin miscompares++; $display("[TB] FAIL frame55_lag: tx at accept %b want 1", txlog[acc % LOGN]); end
        for (int b = 0; b <= 9; b++) begin
            for (int e = 0; e < 2; e++) begin
                k = acc + OS * b + ((e == 0) ? 1 : OS);
                vectors++;
                if (txlog[k % LOGN] !== f[b]) begin
                    miscompares++;
                    $display("[TB] FAIL frame55_bit%0d: tx=%b want %b", b, txlog[k % LOGN], f[b]);
                end
            end
        end
        rdy_bad = 1'b0;
        for (int i = 0; i < 160; i++) if (rdylog[(acc + i) % LOGN] !== 1'b0) rdy_bad = 1'b1;
        vectors++;
        if (rdy_bad !== 1'b0) begin miscompares++; $display("[TB] FAIL frame55_ready_low: ready seen high mid-frame=%b want 0", rdy_bad); end
        vectors++;
        if (rdylog[d % LOGN] !== 1'b1) begin miscompares++; $display("[TB] FAIL frame55_ready_rise: got %b want 1", rdylog[d % LOGN]); end
        vectors++;
        if (busylog[d % LOGN] !== 1'b0) begin miscompares++; $display("[TB] FAIL frame55_busy_end: got %b want 0", busylog[d % LOGN]); end
        @(negedge clk);
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL frame55_done_width: got %b want 0", frame_done); end
    endtask

    task automatic test_parity();
        logic [1:0] se   [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        logic       pexp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int acc, d, k;
        logic [15:0] f;
        for (int v = 0; v < 4; v++) begin
            f = make_frame(9'h003, 7, 1'b1, pexp[v]);
            start_word(9'h003, 4'd7, 1'b1, se[v][0], se[v][1], 2'b00, acc);
            wait_done(400, d);
            vectors++;
            if (d - acc !== 160) begin miscompares++; $display("[TB] FAIL parity%0d_done: got %0d clk want 160", v, d - acc); end
            for (int b = 0; b <= 9; b++) begin
                k = acc + OS * b + OS / 2;
                vectors++;
                if (txlog[k % LOGN] !== f[b]) begin
                    miscompares++;
                    $display("[TB] FAIL parity%0d_bit%0d: tx=%b want %b", v, b, txlog[k % LOGN], f[b]);
                end
            end
        end
    endtask

    task automatic test_nine_bit();
        logic [8:0] dins [4] = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1EA};
        logic [3:0] dbs  [4] = '{4'd9, 4'd9, 4'd15, 4'd3};
        logic [1:0] scs  [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
        int         nds  [4] = '{9, 9, 9, 5};
        int         dns  [4] = '{192, 184, 176, 112};
        int acc, d, k;
        logic [15:0] f;
        for (int v = 0; v < 4; v++) begin
            f = make_frame(dins[v], nds[v], 1'b0, 1'b0);
            start_word(dins[v], dbs[v], 1'b0, 1'b0, 1'b0, scs[v], acc);
            wait_done(400, d);
            vectors++;
            if (d - acc !== dns[v]) begin miscompares++; $display("[TB] FAIL wide%0d_done: got %0d clk want %0d", v, d - acc, dns[v]); end
            for (int b = 0; b <= nds[v] + 1; b++) begin
                k = acc + OS * b + OS / 2;
                vectors++;
                if (txlog[k % LOGN] !== f[b]) begin
                    miscompares++;
                    $display("[TB] FAIL wide%0d_bit%0d: tx=%b want %b", v, b, txlog[k % LOGN], f[b]);
                end
            end
            vectors++;
            if (txlog[d % LOGN] !== 1'b1) begin miscompares++; $display("[TB] FAIL wide%0d_stop_end: tx=%b want 1", v, txlog[d % LOGN]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, d1, d2, k;
        logic [15:0] f1, f2;
        f1 = make_frame(9'h0A5, 8, 1'b0, 1'b0);
        f2 = make_frame(9'h03C, 8, 1'b0, 1'b0);
        @(negedge clk);
        bus.din = 9'h0A5; data_bits = 4'd8; pen = 1'b0; eps = 1'b0;
        sticky_parity = 1'b0; stop_cfg = 2'b00; bus.din_valid = 1'b1;
        acc1 = cyc + 1;
        @(posedge clk);
        #1;
        bus.din = 9'h03C;
        wait_done(400, d1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        wait_done(400, d2);
        acc2 = acc1 + 161;
        vectors++;
        if (d1 - acc1 !== 160) begin miscompares++; $display("[TB] FAIL b2b_done1: got %0d clk want 160", d1 - acc1); end
        vectors++;
        if (d2 - acc1 !== 321) begin miscompares++; $display("[TB] FAIL b2b_done2: got %0d clk want 321", d2 - acc1); end
        vectors++;
        if (busylog[(d1 + 1) % LOGN] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: busy=%b want 1", busylog[(d1 + 1) % LOGN]); end
        for (int b = 0; b <= 9; b++) begin
            k = acc1 + OS * b + OS / 2;
            vectors++;
            if (txlog[k % LOGN] !== f1[b]) begin miscompares++; $display("[TB] FAIL b2b_w1_bit%0d: tx=%b want %b", b, txlog[k % LOGN], f1[b]); end
            k = acc2 + OS * b + ((b == 0) ? 1 : OS / 2);
            vectors++;
            if (txlog[k % LOGN] !== f2[b]) begin miscompares++; $display("[TB] FAIL b2b_w2_bit%0d: tx=%b want %b", b, txlog[k % LOGN], f2[b]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc, d, k, pulses;
        logic [15:0] f;
        start_word(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        while (cyc < acc + 70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_tx: got %b want 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
        vectors++;
        if (bus.din_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_ready: got %b want 0", bus.din_ready); end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.din_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_ready_after: got %b want 1", bus.din_ready); end
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (frame_done !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("[TB] FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
        f = make_frame(9'h0A5, 8, 1'b0, 1'b0);
        start_word(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        wait_done(400, d);
        vectors++;
        if (d - acc !== 160) begin miscompares++; $display("[TB] FAIL rstmid_next_done: got %0d clk want 160", d - acc); end
        for (int b = 0; b <= 9; b++) begin
            k = acc + OS * b + OS / 2;
            vectors++;
            if (txlog[k % LOGN] !== f[b]) begin miscompares++; $display("[TB] FAIL rstmid_next_bit%0d: tx=%b want %b", b, txlog[k % LOGN], f[b]); end
        end
    endtask

    task automatic test_break_config();
        int acc, d;
        logic [15:0] f;
        logic expv;
        f = make_frame(9'h055, 8, 1'b0, 1'b0);
        start_word(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        while (cyc < acc + 30) @(negedge clk);
        set_break = 1'b1;
        data_bits = 4'd5; pen = 1'b1; stop_cfg = 2'b10; bus.din = 9'h000;
        while (cyc < acc + 70) @(negedge clk);
        set_break = 1'b0;
        wait_done(400, d);
        vectors++;
        if (d - acc !== 160) begin miscompares++; $display("[TB] FAIL break_done: got %0d clk want 160", d - acc); end
        for (int k = 1; k <= 160; k++) begin
            expv = (k >= 31 && k <= 70) ? 1'b0 : f[(k - 1) / OS];
            vectors++;
            if (txlog[(acc + k) % LOGN] !== expv) begin
                miscompares++;
                $display("[TB] FAIL break_tx_k%0d: tx=%b want %b", k, txlog[(acc + k) % LOGN], expv);
            end
        end
        @(negedge clk);
        set_break = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_break_tx: got %b want 0", tx); end
        vectors++;
        if (bus.din_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_break_ready: got %b want 1", bus.din_ready); end
        start_word(9'h0C3, 4'd8, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_break_accept: busy=%b want 1", busy); end
        set_break = 1'b0;
        wait_done(400, d);
        vectors++;
        if (d - acc !== 160) begin miscompares++; $display("[TB] FAIL idle_break_done: got %0d clk want 160", d - acc); end
    endtask

    task automatic test_gated_baud();
        int acc, d;
        baud_gate = 1'b1;
        start_word(9'h015, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00, acc);
        wait_done(700, d);
        vectors++;
        if (!((d - acc) == 223 || (d - acc) == 224)) begin
            miscompares++;
            $display("[TB] FAIL gated_done: got %0d clk want 223 or 224", d - acc);
        end
        baud_gate = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.din = '0; bus.din_valid = 1'b0; data_bits = 4'd8;
        pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; stop_cfg = 2'b00; set_break = 1'b0;
        test_reset();
        test_frame_timing();
        test_parity();
        test_nine_bit();
        test_back_to_back();
        test_reset_mid();
        test_break_config();
        test_gated_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
